countdown_timer: RTL and testbench
==================================

# countdown_timer

Parametrised countdown timer, successor to the fixed 60-count, 50 MHz-divided game timer. It counts a run-time-loadable value down to zero, one count per TICK_DIV clocks. It supports pause/resume, abort, restart-on-the-fly and an optional auto-reload (periodic) mode. It sits between the game-control FSM, which drives start/pause/abort, and the display and scoring logic, which consume t, tick, expire and done.

## Interface
Parameters:
- CNT_W, 8, width of the count value t and load_val.
- TICK_DIV, 50000000, clock cycles per count decrement; must be ≥ 2.
- DIV_W, 32, prescaler width; must satisfy 2^DIV_W > TICK_DIV - 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  load load_val and run; sampled every cycle; level-sensitive, so hold for one cycle.
- load_val  in  CNT_W  start count; captured only on a cycle where start=1.
- reload  in  1  auto-reload mode select; captured together with load_val on start.
- pause  in  1  level: while 1, the count and prescaler freeze.
- abort  in  1  return to IDLE; t is held.
- t  out  CNT_W  current count.
- running  out  1  1 in RUN and PAUSED.
- tick  out  1  one-cycle pulse, registered, on each decrement.
- expire  out  1  one-cycle pulse, registered, when the count reaches 0.
- done  out  1  level, 1 in DONE.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
- Registers: t, prescaler (DIV_W bits), rld_val (CNT_W), rld_mode.
- Reset (rst=0, asynchronous):
  - state=IDLE, t=0, prescaler=0, rld_val=0, rld_mode=0.
  - tick=0, expire=0, done=0, running=0.
- Input priority each cycle: abort > start > pause.
- abort=1, any state:
  - state goes to IDLE, prescaler=0.
  - t holds; rld_val and rld_mode hold.
- start=1 (and abort=0), any state, including RUN and PAUSED (restart):
  - t=load_val, rld_val=load_val, rld_mode=reload, prescaler=0.
  - load_val≠0: go to RUN.
  - load_val=0: go to DONE with expire=1 that edge.
- RUN, pause=0:
  - If prescaler ≠ TICK_DIV-1: prescaler increments.
  - If prescaler = TICK_DIV-1: prescaler=0, tick=1, t=t-1.
  - If that decrement takes t from 1 to 0: expire=1, and:
    - rld_mode=0: go to DONE; t stays 0.
    - rld_mode=1: t=rld_val instead of 0 and stay in RUN; expire=1, tick=1, done stays 0.
- RUN, pause=1: go to PAUSED; prescaler and t hold.
- PAUSED:
  - pause=0 returns to RUN; counting resumes from the held prescaler value.
  - No tick while PAUSED.
- DONE:
  - Holds, with t=0, until start or abort.
  - pause has no effect.
- IDLE: holds; t shows the last value.
- Arithmetic: t never decrements below 0. Prescaler compare is an equality test against TICK_DIV-1.
- Illegal state encodings recover to IDLE on the next edge.

## Timing
- All outputs are registered and change only on a rising clk edge, or asynchronously on reset.
- Start sampled at edge E:
  - t=load_val and running=1 are visible after E.
  - First tick occurs at edge E+TICK_DIV.
- One-shot run length is load_val×TICK_DIV cycles after E. At that edge:
  - expire pulses and done rises.
  - t=0 and running falls.
- Each cycle spent in PAUSED extends the run by exactly one cycle. Pause asserted and released costs no extra cycle.
- tick and expire are high for exactly one cycle and coincide on the final decrement.
- Start on the same edge as a natural expiry: the reload from start wins; no expire and no tick that edge.
- Reset mid-run aborts immediately. The first start after reset release behaves as from power-up.

## Test plan
Use TICK_DIV=4 and CNT_W=8 for all scenarios.
1. Reset, then start with load_val=3, reload=0 → t steps 3,2,1,0 every 4 cycles; done=1 and expire pulses exactly 12 cycles after the start edge; t holds at 0.
2. load_val=5, pause held for 7 cycles mid-count → expire is delayed by exactly 7 cycles; no tick occurs while PAUSED; t is unchanged throughout the pause.
3. load_val=2, reload=1 → t sequence 2,1,2,1,…; expire pulses every 8 cycles; done stays 0; abort → IDLE with t held and running=0.
4. load_val=0 start → DONE and expire=1 on the next edge; no tick pulse.
5. Restart at t=4 with load_val=9 → t=9 and prescaler=0 on the next edge. Separately, start coinciding with the expiry edge → no expire, t=load_val.
6. rst pulsed low mid-count (async, between clock edges) → all outputs are 0 immediately; after release the block stays in IDLE until start.

Source files
------------

// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer
// Description : Parametrised countdown timer. Loads a run-time value on start
//               and counts it down to zero, one count per TICK_DIV clocks.
//               Supports pause/resume, abort, restart while running, and an
//               optional auto-reload (periodic) mode.
// Ports       : clk      - clock, all state changes on the rising edge
//               rst      - asynchronous active-low reset
//               start    - load load_val/reload and run (single-cycle level)
//               load_val - start count
//               reload   - auto-reload mode, captured with load_val
//               pause    - freezes count and prescaler while high
//               abort    - return to IDLE, count held
//               t        - current count
//               running  - high in RUN and PAUSED
//               tick     - one-cycle pulse on each decrement
//               expire   - one-cycle pulse when the count reaches zero
//               done     - high while in DONE
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer #(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = 50000000,  // must be >= 2
    parameter int DIV_W    = 32         // must hold TICK_DIV-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic             reload,
    input  logic             pause,
    input  logic             abort,
    output logic [CNT_W-1:0] t,
    output logic             running,
    output logic             tick,
    output logic             expire,
    output logic             done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0] PRE_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [DIV_W-1:0] prescaler;
    logic [DIV_W-1:0] prescaler_nx;
    logic [CNT_W-1:0] t_nx;
    logic [CNT_W-1:0] rld_val;
    logic [CNT_W-1:0] rld_val_nx;
    logic             rld_mode;
    logic             rld_mode_nx;
    logic             tick_nx;
    logic             expire_nx;
    logic             running_nx;
    logic             done_nx;

    // ------------------------------------------------------------------------
    // State and datapath registers; every output is a flop.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            t         <= '0;
            prescaler <= '0;
            rld_val   <= '0;
            rld_mode  <= 1'b0;
            tick      <= 1'b0;
            expire    <= 1'b0;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            t         <= t_nx;
            prescaler <= prescaler_nx;
            rld_val   <= rld_val_nx;
            rld_mode  <= rld_mode_nx;
            tick      <= tick_nx;
            expire    <= expire_nx;
            running   <= running_nx;
            done      <= done_nx;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Priority: abort > start > pause.
    // ------------------------------------------------------------------------
    always_comb begin
        state_nx     = state;
        t_nx         = t;
        prescaler_nx = prescaler;
        rld_val_nx   = rld_val;
        rld_mode_nx  = rld_mode;
        tick_nx      = 1'b0;
        expire_nx    = 1'b0;

        if (abort) begin
            state_nx     = S_IDLE;
            prescaler_nx = '0;
        end else if (start) begin
            // Restart is allowed from any state and overrides a coincident
            // natural expiry, so no tick/expire is raised here unless the
            // loaded value is already zero.
            t_nx         = load_val;
            rld_val_nx   = load_val;
            rld_mode_nx  = reload;
            prescaler_nx = '0;
            if (load_val != '0) begin
                state_nx = S_RUN;
            end else begin
                state_nx  = S_DONE;
                expire_nx = 1'b1;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state_nx = S_IDLE;
                end
                // The edge that releases a pause performs a normal counting
                // step, so only cycles actually spent paused delay the run.
                S_RUN, S_PAUSED: begin
                    if (pause) begin
                        state_nx = S_PAUSED;
                    end else begin
                        state_nx = S_RUN;
                        if (prescaler == PRE_LAST) begin
                            prescaler_nx = '0;
                            if (t != '0) begin
                                tick_nx = 1'b1;
                                if (t == CNT_ONE) begin
                                    expire_nx = 1'b1;
                                    if (rld_mode) begin
                                        t_nx = rld_val;
                                    end else begin
                                        t_nx     = '0;
                                        state_nx = S_DONE;
                                    end
                                end else begin
                                    t_nx = t - CNT_ONE;
                                end
                            end else begin
                                // Zero count in RUN cannot be reached normally;
                                // settle in DONE without underflowing.
                                state_nx = S_DONE;
                            end
                        end else begin
                            prescaler_nx = prescaler + PRE_ONE;
                        end
                    end
                end
                S_DONE: begin
                    state_nx = S_DONE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode, taken from the next state so the level outputs are
    // registered alongside the state.
    // ------------------------------------------------------------------------
    always_comb begin
        running_nx = (state_nx == S_RUN) || (state_nx == S_PAUSED);
        done_nx    = (state_nx == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_countdown_timer
// Description : Scoreboard bench for countdown_timer (CNT_W=8, TICK_DIV=4).
//               Stimulus queues expected output snapshots tagged with the
//               cycle they must appear on; a monitor compares them and flags
//               any tick/expire pulse that nothing expected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

    localparam int CNT_W    = 8;
    localparam int TICK_DIV = 4;
    localparam int DIV_W    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] load_val = '0;
    logic             reload = 1'b0;
    logic             pause = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] t;
    logic             running;
    logic             tick;
    logic             expire;
    logic             done;

    countdown_timer #(
        .CNT_W    (CNT_W),
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .reload   (reload),
        .pause    (pause),
        .abort    (abort),
        .t        (t),
        .running  (running),
        .tick     (tick),
        .expire   (expire),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] t;
        logic       tick;
        logic       expire;
        logic       done;
        logic       running;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // ------------------------------------------------------------------------
    // Monitor: sample away from the active edge.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL %s: expected snapshot at cycle %0d was never sampled (now %0d)",
                     e.name, e.cyc, cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            tests = tests + 1;
            if ({t, tick, expire, done, running} !==
                {e.t, e.tick, e.expire, e.done, e.running}) begin
                fails = fails + 1;
                $display("FAIL %s @%0d: got t=%0d tick=%b expire=%b done=%b running=%b, expected t=%0d tick=%b expire=%b done=%b running=%b",
                         e.name, cyc, t, tick, expire, done, running,
                         e.t, e.tick, e.expire, e.done, e.running);
            end
        end else if (tick !== 1'b0 || expire !== 1'b0) begin
            tests = tests + 1;
            fails = fails + 1;
            $display("FAIL unexpected_pulse @%0d: got tick=%b expire=%b t=%0d, expected tick=0 expire=0",
                     cyc, tick, expire, t);
        end
    end

    // ------------------------------------------------------------------------
    // Expectation helpers
    // ------------------------------------------------------------------------
    task automatic expect_at(input int c, input logic [7:0] tv, input logic tk,
                             input logic ex, input logic dn, input logic rn,
                             input string nm);
        exp_t e;
        e.cyc = c; e.t = tv; e.tick = tk; e.expire = ex;
        e.done = dn; e.running = rn; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic ev_tick(input int c, input logic [7:0] tv, input string nm);
        expect_at(c, tv, 1'b1, 1'b0, 1'b0, 1'b1, nm);
    endtask

    task automatic ev_reload(input int c, input logic [7:0] tv, input string nm);
        expect_at(c, tv, 1'b1, 1'b1, 1'b0, 1'b1, nm);
    endtask

    task automatic ev_finish(input int c, input string nm);
        expect_at(c, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, nm);
    endtask

    task automatic probe(input int c, input logic [7:0] tv, input logic dn,
                         input logic rn, input string nm);
        expect_at(c, tv, 1'b0, 1'b0, dn, rn, nm);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called right after a negedge; start is sampled on the next rising edge.
    task automatic pulse_start(input logic [7:0] v, input logic r);
        start    = 1'b1;
        load_val = v;
        reload   = r;
        @(negedge clk);
        start    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int e;
        int e2;
        int e3;
        int e4;
        int e5;

        // Reset state while rst is held low, and idle after release.
        probe(2, 8'd0, 1'b0, 1'b0, "reset_state");
        probe(4, 8'd0, 1'b0, 1'b0, "idle_after_reset");
        wait_until(3);
        rst = 1'b1;
        wait_until(5);

        // 1: one-shot of 3 -> 12 cycles.
        e = cyc + 1;
        ev_tick(e + 4, 8'd2, "s1_tick1");
        ev_tick(e + 8, 8'd1, "s1_tick2");
        probe(e + 11, 8'd1, 1'b0, 1'b1, "s1_before_expire");
        ev_finish(e + 12, "s1_expire");
        probe(e + 15, 8'd0, 1'b1, 1'b0, "s1_done_hold");
        pulse_start(8'd3, 1'b0);
        wait_until(e + 16);

        // 2: load 5, pause sampled on 7 edges -> expiry moves from +20 to +27.
        e = cyc + 1;
        ev_tick(e + 4, 8'd4, "s2_tick1");
        probe(e + 9, 8'd4, 1'b0, 1'b1, "s2_paused_mid");
        probe(e + 12, 8'd4, 1'b0, 1'b1, "s2_paused_end");
        ev_tick(e + 15, 8'd3, "s2_tick2");
        ev_tick(e + 19, 8'd2, "s2_tick3");
        ev_tick(e + 23, 8'd1, "s2_tick4");
        ev_finish(e + 27, "s2_expire");
        pulse_start(8'd5, 1'b0);
        wait_until(e + 5);
        pause = 1'b1;
        wait_until(e + 12);
        pause = 1'b0;
        wait_until(e + 28);

        // 3: periodic reload of 2, then abort.
        e = cyc + 1;
        ev_tick(e + 4, 8'd1, "s3_tick_a");
        ev_reload(e + 8, 8'd2, "s3_reload_a");
        ev_tick(e + 12, 8'd1, "s3_tick_b");
        ev_reload(e + 16, 8'd2, "s3_reload_b");
        ev_tick(e + 20, 8'd1, "s3_tick_c");
        ev_reload(e + 24, 8'd2, "s3_reload_c");
        probe(e + 28, 8'd2, 1'b0, 1'b0, "s3_abort_t_held");
        probe(e + 33, 8'd2, 1'b0, 1'b0, "s3_idle_stays");
        pulse_start(8'd2, 1'b1);
        wait_until(e + 26);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_until(e + 34);

        // 4: zero load goes straight to DONE with expire, no tick.
        e = cyc + 1;
        expect_at(e, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, "s4_zero_load");
        probe(e + 3, 8'd0, 1'b1, 1'b0, "s4_done_hold");
        pulse_start(8'd0, 1'b0);
        wait_until(e + 4);

        // 5a: restart at t=4 with 9; prescaler must restart from zero.
        e  = cyc + 1;
        e2 = e + 10;
        ev_tick(e + 4, 8'd5, "s5_tick1");
        ev_tick(e + 8, 8'd4, "s5_tick2");
        probe(e2, 8'd9, 1'b0, 1'b1, "s5_restart_load");
        ev_tick(e2 + 4, 8'd8, "s5_restart_tick1");
        ev_tick(e2 + 8, 8'd7, "s5_restart_tick2");
        probe(e2 + 11, 8'd7, 1'b0, 1'b0, "s5_abort_held");
        pulse_start(8'd6, 1'b0);
        wait_until(e + 9);
        pulse_start(8'd9, 1'b0);
        wait_until(e2 + 9);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_until(e2 + 12);

        // 5b: start on the natural expiry edge wins; no pulse that edge.
        e3 = cyc + 1;
        probe(e3 + 4, 8'd3, 1'b0, 1'b1, "s5_start_beats_expiry");
        ev_tick(e3 + 8, 8'd2, "s5b_tick1");
        ev_tick(e3 + 12, 8'd1, "s5b_tick2");
        ev_finish(e3 + 16, "s5b_expire");
        pulse_start(8'd1, 1'b0);
        wait_until(e3 + 3);
        pulse_start(8'd3, 1'b0);
        wait_until(e3 + 17);

        // 6: short reset pulse entirely between edges, then fresh start.
        e4 = cyc + 1;
        e5 = e4 + 14;
        ev_tick(e4 + 4, 8'd4, "s6_tick_before_reset");
        probe(e4 + 7, 8'd0, 1'b0, 1'b0, "s6_async_reset");
        probe(e4 + 12, 8'd0, 1'b0, 1'b0, "s6_idle_after_reset");
        ev_tick(e5 + 4, 8'd1, "s6_fresh_tick");
        ev_finish(e5 + 8, "s6_fresh_expire");
        pulse_start(8'd5, 1'b0);
        wait_until(e4 + 6);
        #1 rst = 1'b0;
        #2 rst = 1'b1;
        wait_until(e4 + 13);
        pulse_start(8'd2, 1'b0);
        wait_until(e5 + 10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
